// File: rtl/proc_input_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_arb_pkg
// Description : Shared defaults, ID width helper and tag type for the
//               processor input arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_arb_pkg;

  localparam int          DEF_DATA_W    = 16;
  localparam logic [15:0] DEF_IDLE_WORD = 16'h0000;

  // Widest requester ID supported (NUM_REQ up to 16).
  localparam int MAX_ID_W = 4;

  // Requester ID width: max(1, clog2(n)).
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Tag carried alongside each issued word; id is zero-extended to MAX_ID_W.
  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/proc_input_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. Scans from the slot after the last
//               winner; the pointer moves to the winner on every grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,        // asynchronous, active-low
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;

  // Pick the first requester after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (en && !grant_any && req[idx]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
    ptr_d = grant_any ? grant_idx : ptr_q;
  end

  // Pointer register; resets to the last slot so requester 0 wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= ID_W'(NUM_REQ - 1);
    else      ptr_q <= ptr_d;
  end

endmodule
`default_nettype wire

// File: rtl/proc_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : proc_input_arbiter
// Description : Shares the processor data_in port between NUM_REQ requesters
//               and routes each result back with its requester ID.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_input_arbiter
  import proc_arb_pkg::*;
#(
  parameter int                NUM_REQ   = 4,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                PROC_LAT  = 2,
  parameter logic [DATA_W-1:0] IDLE_WORD = DATA_W'(DEF_IDLE_WORD),
  localparam int               ID_W      = id_width(NUM_REQ),
  localparam int               OUT_W     = $clog2(PROC_LAT + 2)
) (
  input  logic                      clk,
  input  logic                      rst,          // asynchronous, active-low
  input  logic                      pause,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         proc_data_in,
  input  logic [DATA_W-1:0]         proc_data_out,
  output logic                      resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_data,
  output logic [OUT_W-1:0]          outstanding
);

  logic [ID_W-1:0] grant_idx;
  logic            grant_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .en        (!pause),
    .grant     (req_ready),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  logic [DATA_W-1:0]         proc_data_in_q, proc_data_in_d;
  tag_t [PROC_LAT-1:0]       tag_q, tag_d;
  logic                      resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]           resp_id_q, resp_id_d;
  logic [DATA_W-1:0]         resp_data_q, resp_data_d;
  logic [OUT_W-1:0]          outstanding_q, outstanding_d;
  tag_t                      last_tag;

  // Issue, tag shift, response capture and in-flight count.
  always_comb begin
    last_tag       = tag_q[PROC_LAT-1];
    proc_data_in_d = grant_any ? req_data[int'(grant_idx)*DATA_W +: DATA_W] : IDLE_WORD;

    tag_d          = tag_q;
    tag_d[0].valid = grant_any;
    tag_d[0].id    = MAX_ID_W'(grant_idx);
    for (int k = 1; k < PROC_LAT; k++) tag_d[k] = tag_q[k-1];

    // The tag at the last stage lines up with its result on proc_data_out.
    resp_valid_d = last_tag.valid;
    resp_id_d    = last_tag.valid ? ID_W'(last_tag.id) : resp_id_q;
    resp_data_d  = last_tag.valid ? proc_data_out : resp_data_q;

    outstanding_d = outstanding_q;
    if (grant_any && !last_tag.valid)      outstanding_d = outstanding_q + OUT_W'(1);
    else if (!grant_any && last_tag.valid) outstanding_d = outstanding_q - OUT_W'(1);
  end

  // State registers; reset discards every in-flight tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      proc_data_in_q <= IDLE_WORD;
      tag_q          <= '0;
      resp_valid_q   <= 1'b0;
      resp_id_q      <= '0;
      resp_data_q    <= '0;
      outstanding_q  <= '0;
    end else begin
      proc_data_in_q <= proc_data_in_d;
      tag_q          <= tag_d;
      resp_valid_q   <= resp_valid_d;
      resp_id_q      <= resp_id_d;
      resp_data_q    <= resp_data_d;
      outstanding_q  <= outstanding_d;
    end
  end

  assign proc_data_in = proc_data_in_q;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_data    = resp_data_q;
  assign outstanding  = outstanding_q;

endmodule
`default_nettype wire

// File: tb/tb_proc_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_input_arbiter
// Description : Scoreboard bench for proc_input_arbiter (4 req / lat 2 and
//               2 req / lat 1 builds) with a data+1 processor model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_input_arbiter;

  typedef struct {
    int          id;
    logic [15:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- build A: NUM_REQ=4, PROC_LAT=2 ----------------
  logic        pause_a = 1'b0;
  logic [3:0]  req_valid_a = '0;
  logic [63:0] req_data_a = '0;
  logic [3:0]  req_ready_a;
  logic [15:0] pdi_a, pdo_a, resp_data_a, proc_reg_a;
  logic        resp_valid_a;
  logic [1:0]  resp_id_a, outstanding_a;

  proc_input_arbiter #(.NUM_REQ(4), .DATA_W(16), .PROC_LAT(2), .IDLE_WORD(16'h0000)) dut_a (
    .clk(clk), .rst(rst), .pause(pause_a), .req_valid(req_valid_a), .req_data(req_data_a),
    .req_ready(req_ready_a), .proc_data_in(pdi_a), .proc_data_out(pdo_a),
    .resp_valid(resp_valid_a), .resp_id(resp_id_a), .resp_data(resp_data_a),
    .outstanding(outstanding_a));

  // Processor model: the issue register plus one register stage give 2 edges.
  always @(posedge clk) proc_reg_a <= pdi_a + 16'd1;
  assign pdo_a = proc_reg_a;

  // ---------------- build B: NUM_REQ=2, PROC_LAT=1 ----------------
  logic        pause_b = 1'b0;
  logic [1:0]  req_valid_b = '0;
  logic [31:0] req_data_b = '0;
  logic [1:0]  req_ready_b;
  logic [15:0] pdi_b, pdo_b, resp_data_b;
  logic        resp_valid_b;
  logic [0:0]  resp_id_b;
  logic [1:0]  outstanding_b;
  int          hs_b = 0;

  proc_input_arbiter #(.NUM_REQ(2), .DATA_W(16), .PROC_LAT(1), .IDLE_WORD(16'h0000)) dut_b (
    .clk(clk), .rst(rst), .pause(pause_b), .req_valid(req_valid_b), .req_data(req_data_b),
    .req_ready(req_ready_b), .proc_data_in(pdi_b), .proc_data_out(pdo_b),
    .resp_valid(resp_valid_b), .resp_id(resp_id_b), .resp_data(resp_data_b),
    .outstanding(outstanding_b));

  assign pdo_b = pdi_b + 16'd1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [15:0] v, input int n);
    for (int k = 1; k <= n; k++)
      if (v[(ptr + k) % n]) return (ptr + k) % n;
    return -1;
  endfunction

  // ---------------- scoreboard A ----------------
  exp_t        qa[$];
  int          ptr_a = 3;
  logic [15:0] exp_pdi_a = '0;
  int          last_id_a = 0;
  logic [15:0] last_data_a = '0;

  always @(negedge clk) begin
    exp_t e;
    int   w;
    if (!rst) begin
      qa.delete();
      ptr_a = 3; exp_pdi_a = '0; last_id_a = 0; last_data_a = '0;
    end else begin
      chk("a_proc_data_in", pdi_a, exp_pdi_a);
      if (resp_valid_a) begin
        if (qa.size() == 0) chk("a_spurious_resp", resp_valid_a, 0);
        else begin
          e = qa.pop_front();
          chk("a_resp_id", resp_id_a, e.id);
          chk("a_resp_data", resp_data_a, e.data);
          chk("a_resp_latency", cyc, e.due);
          last_id_a = e.id; last_data_a = e.data;
        end
      end else begin
        chk("a_resp_id_hold", resp_id_a, last_id_a);
        chk("a_resp_data_hold", resp_data_a, last_data_a);
      end
      chk("a_outstanding", outstanding_a, qa.size());
      w = rr_pick(ptr_a, pause_a ? 16'h0 : {12'h0, req_valid_a}, 4);
      chk("a_req_ready", req_ready_a, (w >= 0) ? (32'd1 << w) : 32'd0);
      if (w >= 0) begin
        e.id = w; e.data = req_data_a[w*16 +: 16] + 16'd1; e.due = cyc + 3;
        qa.push_back(e);
        ptr_a = w; exp_pdi_a = req_data_a[w*16 +: 16];
      end else exp_pdi_a = '0;
    end
  end

  // ---------------- scoreboard B ----------------
  exp_t qb[$];
  int   ptr_b = 1;

  always @(negedge clk) begin
    exp_t e;
    int   w;
    if (!rst) begin
      qb.delete(); ptr_b = 1;
    end else begin
      if (resp_valid_b) begin
        if (qb.size() == 0) chk("b_spurious_resp", resp_valid_b, 0);
        else begin
          e = qb.pop_front();
          chk("b_resp_id", resp_id_b, e.id);
          chk("b_resp_data", resp_data_b, e.data);
          chk("b_resp_latency", cyc, e.due);
        end
      end
      chk("b_outstanding", outstanding_b, qb.size());
      w = rr_pick(ptr_b, pause_b ? 16'h0 : {14'h0, req_valid_b}, 2);
      chk("b_req_ready", req_ready_b, (w >= 0) ? (32'd1 << w) : 32'd0);
      if (w >= 0) begin
        e.id = w; e.data = req_data_b[w*16 +: 16] + 16'd1; e.due = cyc + 2;
        qb.push_back(e);
        ptr_b = w; hs_b++;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 10000", cyc);
    $fatal(1);
  end

  initial begin
    tick(2);
    chk("reset_proc_data_in", pdi_a, 16'h0000);
    chk("reset_resp_valid", resp_valid_a, 0);
    chk("reset_resp_id", resp_id_a, 0);
    chk("reset_resp_data", resp_data_a, 0);
    chk("reset_outstanding", outstanding_a, 0);
    rst = 1'b1;
    tick(1);

    // 1: single request from requester 2
    req_valid_a = 4'b0100;
    req_data_a[2*16 +: 16] = 16'h1234;
    #1 chk("t1_ready", req_ready_a, 4'b0100);
    tick(1);
    req_valid_a = '0;
    chk("t1_proc_data_in", pdi_a, 16'h1234);
    chk("t1_outstanding", outstanding_a, 1);
    tick(2);
    chk("t1_resp_valid", resp_valid_a, 1);
    chk("t1_resp_id", resp_id_a, 2);
    chk("t1_resp_data", resp_data_a, 16'h1235);
    chk("t1_outstanding_end", outstanding_a, 0);
    tick(3);

    // 2: all four streaming
    for (int i = 0; i < 4; i++) req_data_a[i*16 +: 16] = 16'hA000 + 16'(i);
    req_valid_a = 4'b1111;
    tick(9);
    req_valid_a = '0;
    tick(4);

    // 3: requesters 1 and 3 only
    req_data_a[1*16 +: 16] = 16'h5501;
    req_data_a[3*16 +: 16] = 16'h5503;
    req_valid_a = 4'b1010;
    tick(7);
    req_valid_a = '0;
    tick(4);

    // 4: streaming with a 3-cycle pause
    req_valid_a = 4'b1111;
    tick(3);
    pause_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_paused_ready", req_ready_a, 4'b0000);
      tick(1);
    end
    chk("t4_drained", outstanding_a, 0);
    pause_a = 1'b0;
    tick(3);
    req_valid_a = '0;
    tick(4);

    // 5: reset while two words are in flight
    req_valid_a = 4'b1111;
    tick(3);
    chk("t5_outstanding_pre", outstanding_a, 2);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_outstanding", outstanding_a, 0);
    chk("t5_async_resp_valid", resp_valid_a, 0);
    chk("t5_async_proc_data_in", pdi_a, 16'h0000);
    chk("t5_async_resp_data", resp_data_a, 0);
    req_valid_a = '0;
    tick(2);
    rst = 1'b1;
    tick(3);
    req_valid_a = 4'b1111;
    #1 chk("t5_first_grant", req_ready_a, 4'b0001);
    tick(2);
    req_valid_a = '0;
    tick(4);

    // 6: two-requester, latency-1 build, requester 0 alone
    req_data_b = {16'hBBBB, 16'h0C00};
    hs_b = 0;
    req_valid_b = 2'b01;
    tick(5);
    req_valid_b = '0;
    tick(3);
    chk("t6_handshakes", hs_b, 5);

    chk("end_queue_a", qa.size(), 0);
    chk("end_queue_b", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
